// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the four-master bus arbiter.
// Optional tenure timeout is enabled with the BUS_ARB_TIMEOUT_EN macro.
package bus_arbiter_pkg;

    localparam int unsigned BUS_MASTER_CH = 4;
    localparam int unsigned BUS_OWNER_W   = 2;

    typedef logic [BUS_OWNER_W-1:0]   bus_owner_t;
    typedef logic [BUS_MASTER_CH-1:0] bus_req_t;
    typedef logic [7:0]               bus_arb_tenure_t;

    localparam bus_owner_t BUS_OWNER_M0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_M1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_M2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_M3 = 2'd3;

    typedef enum logic {
        BUS_ARB_IDLE  = 1'b0,
        BUS_ARB_OWNED = 1'b1
    } bus_arb_state_t;

    // One-hot grant vector for a given owner index
    function automatic bus_req_t bus_owner_onehot(input bus_owner_t owner);
        bus_req_t vec;
        case (owner)
            BUS_OWNER_M0: vec = 4'b0001;
            BUS_OWNER_M1: vec = 4'b0010;
            BUS_OWNER_M2: vec = 4'b0100;
            BUS_OWNER_M3: vec = 4'b1000;
            default:      vec = '0;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, skipping
// any master set in `excl`.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0] req,
    input  logic [BUS_OWNER_W-1:0]   last,
    input  logic [BUS_MASTER_CH-1:0] excl,
    output logic                     found,
    output logic [BUS_OWNER_W-1:0]   winner
);

    logic [BUS_MASTER_CH-1:0] avail;

    assign avail = req & ~excl;

    // Scan from farthest to nearest so the nearest candidate after last wins
    always_comb begin
        found  = 1'b0;
        winner = last;
        for (int unsigned i = BUS_MASTER_CH; i >= 1; i--) begin
            if (avail[last + BUS_OWNER_W'(i)]) begin
                found  = 1'b1;
                winner = last + BUS_OWNER_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with registered one-hot grants.
// Define BUS_ARB_TIMEOUT_EN to enable tenure timeout and preemption.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TENURE_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic                   bus_m0_req,
    input  logic                   bus_m1_req,
    input  logic                   bus_m2_req,
    input  logic                   bus_m3_req,
    output logic                   bus_m0_grnt,
    output logic                   bus_m1_grnt,
    output logic                   bus_m2_grnt,
    output logic                   bus_m3_grnt,
    output logic [BUS_OWNER_W-1:0] bus_owner,
    output logic                   bus_busy,
    output logic                   bus_arb_preempt
);

    if (TENURE_MAX < 2 || TENURE_MAX > 255) begin : g_bad_tenure
        $error("bus_arbiter: TENURE_MAX must be in 2..255");
    end

    bus_arb_state_t state;
    bus_req_t       req;
    bus_req_t       grnt_q;
    bus_owner_t     owner_q;
    bus_owner_t     last_q;
    logic           busy_q;

    bus_owner_t     pick_last;
    bus_req_t       pick_excl;
    logic           pick_found;
    bus_owner_t     pick_winner;
    logic           owner_req;

    assign req       = {bus_m3_req, bus_m2_req, bus_m1_req, bus_m0_req};
    assign owner_req = req[owner_q];

    // While owned, search from the owner with the owner masked out: this one
    // lookup serves both voluntary handover (owner req is low anyway) and
    // preemption (owner req still high).
    assign pick_last = (state == BUS_ARB_OWNED) ? owner_q : last_q;
    assign pick_excl = (state == BUS_ARB_OWNED) ? bus_owner_onehot(owner_q) : '0;

    bus_arb_rr_pick u_pick (
        .req    (req),
        .last   (pick_last),
        .excl   (pick_excl),
        .found  (pick_found),
        .winner (pick_winner)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam bus_arb_tenure_t TENURE_LAST = bus_arb_tenure_t'(TENURE_MAX - 1);

    bus_arb_tenure_t tenure_q;
    logic            preempt_q;
`endif

    // Arbitration state machine with registered grants, owner and busy
    always_ff @(posedge clk) begin
        if (!rest) begin
            state   <= BUS_ARB_IDLE;
            grnt_q  <= '0;
            busy_q  <= 1'b0;
            owner_q <= BUS_OWNER_M0;
            last_q  <= BUS_OWNER_M3;
`ifdef BUS_ARB_TIMEOUT_EN
            tenure_q  <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            preempt_q <= 1'b0;
`endif
            case (state)
                BUS_ARB_IDLE: begin
                    if (pick_found) begin
                        state   <= BUS_ARB_OWNED;
                        grnt_q  <= bus_owner_onehot(pick_winner);
                        busy_q  <= 1'b1;
                        owner_q <= pick_winner;
`ifdef BUS_ARB_TIMEOUT_EN
                        tenure_q <= '0;
`endif
                    end
                end
                BUS_ARB_OWNED: begin
                    if (!owner_req) begin
                        last_q <= owner_q;
`ifdef BUS_ARB_TIMEOUT_EN
                        tenure_q <= '0;
`endif
                        if (pick_found) begin
                            grnt_q  <= bus_owner_onehot(pick_winner);
                            owner_q <= pick_winner;
                        end else begin
                            state  <= BUS_ARB_IDLE;
                            grnt_q <= '0;
                            busy_q <= 1'b0;
                        end
                    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                        if (tenure_q == TENURE_LAST) begin
                            if (pick_found) begin
                                preempt_q <= 1'b1;
                                last_q    <= owner_q;
                                grnt_q    <= bus_owner_onehot(pick_winner);
                                owner_q   <= pick_winner;
                                tenure_q  <= '0;
                            end
                        end else begin
                            tenure_q <= tenure_q + 8'd1;
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign bus_m0_grnt = grnt_q[0];
    assign bus_m1_grnt = grnt_q[1];
    assign bus_m2_grnt = grnt_q[2];
    assign bus_m3_grnt = grnt_q[3];
    assign bus_owner   = owner_q;
    assign bus_busy    = busy_q;

`ifdef BUS_ARB_TIMEOUT_EN
    assign bus_arb_preempt = preempt_q;
`else
    assign bus_arb_preempt = 1'b0;
`endif

endmodule
